// File: rtl/freq_divider_prog.sv
// Programmable integer clock divider with double-buffered ratio and period-start pulse.
// Define FREQ_DIV_FRAC_EN to add the 4-bit fractional-N accumulator.
module freq_divider_prog #(
    parameter int DIV_W    = 8,
    parameter int DIV_INIT = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] ndiv,
    input  logic             ndiv_load,
    input  logic [3:0]       frac,
    output logic             div_out,
    output logic             div_pulse,
    output logic             ndiv_ack
);

    logic [DIV_W-1:0] act_n;
    logic [DIV_W-1:0] sh_n;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] len_m1;
    logic             pend;
    logic             started;

    logic             boundary;
    logic             carry;
    logic [DIV_W-1:0] nxt_n;
    logic [DIV_W-1:0] nxt_len_m1;
    logic [DIV_W:0]   len;
    logic [DIV_W:0]   high_len;
    logic [DIV_W:0]   cnt_inc;

    // A ratio of zero behaves as divide-by-one.
    function automatic logic [DIV_W-1:0] effective_ratio(input logic [DIV_W-1:0] n);
        return (n == '0) ? DIV_W'(1) : n;
    endfunction

`ifdef FREQ_DIV_FRAC_EN
    logic [3:0] acc;
    logic [4:0] acc_sum;

    assign acc_sum = {1'b0, acc} + {1'b0, frac};
    assign carry   = acc_sum[4];

    always_ff @(posedge clk) begin
        if (reset)
            acc <= '0;
        else if (boundary)
            acc <= acc_sum[3:0];
    end
`else
    logic unused_frac;

    assign unused_frac = ^frac;
    assign carry       = 1'b0;
`endif

    always_comb begin
        boundary   = enable && (!started || (cnt == len_m1));
        nxt_n      = pend ? sh_n : act_n;
        // Ne-1+carry stays below 2^DIV_W because Ne never exceeds 2^DIV_W-1.
        nxt_len_m1 = effective_ratio(nxt_n) - DIV_W'(1) + DIV_W'(carry);
        len        = {1'b0, len_m1} + (DIV_W+1)'(1);
        high_len   = len - (len >> 1);
        cnt_inc    = {1'b0, cnt} + (DIV_W+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_n     <= DIV_W'(DIV_INIT);
            sh_n      <= DIV_W'(DIV_INIT);
            pend      <= 1'b0;
            cnt       <= '0;
            len_m1    <= DIV_W'(DIV_INIT - 1);
            started   <= 1'b0;
            div_out   <= 1'b0;
            div_pulse <= 1'b0;
            ndiv_ack  <= 1'b0;
        end else begin
            if (ndiv_load)
                sh_n <= ndiv;
            // A load on a boundary edge stays pending for the following boundary.
            pend <= ndiv_load || (pend && !boundary);

            if (boundary) begin
                cnt       <= '0;
                len_m1    <= nxt_len_m1;
                act_n     <= nxt_n;
                started   <= 1'b1;
                div_out   <= 1'b1;
                div_pulse <= 1'b1;
                ndiv_ack  <= pend;
            end else if (enable) begin
                cnt       <= cnt_inc[DIV_W-1:0];
                div_out   <= (cnt_inc < high_len);
                div_pulse <= 1'b0;
                ndiv_ack  <= 1'b0;
            end else begin
                div_pulse <= 1'b0;
                ndiv_ack  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_freq_divider_prog.sv
// Directed bench for freq_divider_prog; observed word is {div_out, div_pulse, ndiv_ack}.
module tb_freq_divider_prog;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [7:0] ndiv;
    logic       ndiv_load;
    logic [3:0] frac;
    logic       div_out;
    logic       div_pulse;
    logic       ndiv_ack;

    int errors = 0;
    int checks = 0;

    freq_divider_prog #(.DIV_W(8), .DIV_INIT(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .ndiv      (ndiv),
        .ndiv_load (ndiv_load),
        .frac      (frac),
        .div_out   (div_out),
        .div_pulse (div_pulse),
        .ndiv_ack  (ndiv_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    // Advance one rising edge; returns on the following falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        ndiv_load = 1'b0;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [2:0] obs;
        reset = 1'b1; enable = 1'b1; ndiv = 8'd9; ndiv_load = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            obs = {div_out, div_pulse, ndiv_ack};
            checks++;
            if (obs !== 3'b000) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %b expected 000", i, obs);
            end
        end
        reset = 1'b0; ndiv_load = 1'b0;
        cyc();
        obs = {div_out, div_pulse, ndiv_ack};
        checks++;
        if (obs !== 3'b110) begin
            errors++;
            $display("FAIL reset_first_edge: got %b expected 110", obs);
        end
    endtask

    task automatic test_div2();
        logic [2:0] obs, exp;
        apply_reset();
        enable = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            obs = {div_out, div_pulse, ndiv_ack};
            exp = (i % 2 == 0) ? 3'b110 : 3'b000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL div2[%0d]: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_load5();
        logic [2:0] obs, exp;
        apply_reset();
        enable = 1'b1;
        cyc();
        ndiv = 8'd5; ndiv_load = 1'b1;
        cyc();
        ndiv_load = 1'b0;
        obs = {div_out, div_pulse, ndiv_ack};
        checks++;
        if (obs !== 3'b000) begin
            errors++;
            $display("FAIL load5_load_edge: got %b expected 000", obs);
        end
        for (int j = 0; j < 11; j++) begin
            cyc();
            obs = {div_out, div_pulse, ndiv_ack};
            exp = {(j % 5) < 3, (j % 5) == 0, j == 0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL load5[%0d]: got %b expected %b", j, obs, exp);
            end
        end
    endtask

    task automatic test_n0_n1_n255();
        logic [2:0] obs, exp;
        apply_reset();
        enable = 1'b1;
        cyc();
        ndiv = 8'd0; ndiv_load = 1'b1;
        cyc();
        ndiv_load = 1'b0;
        for (int j = 0; j < 5; j++) begin
            cyc();
            obs = {div_out, div_pulse, ndiv_ack};
            exp = {2'b11, j == 0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL n0[%0d]: got %b expected %b", j, obs, exp);
            end
        end
        ndiv = 8'd1; ndiv_load = 1'b1;
        for (int j = 0; j < 4; j++) begin
            cyc();
            ndiv_load = 1'b0;
            obs = {div_out, div_pulse, ndiv_ack};
            exp = {2'b11, j == 1};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL n1[%0d]: got %b expected %b", j, obs, exp);
            end
        end
        ndiv = 8'd255; ndiv_load = 1'b1;
        cyc();
        ndiv_load = 1'b0;
        obs = {div_out, div_pulse, ndiv_ack};
        checks++;
        if (obs !== 3'b110) begin
            errors++;
            $display("FAIL n255_load_edge: got %b expected 110", obs);
        end
        for (int j = 0; j < 256; j++) begin
            cyc();
            obs = {div_out, div_pulse, ndiv_ack};
            exp = {(j < 128) || (j == 255), (j == 0) || (j == 255), j == 0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL n255[%0d]: got %b expected %b", j, obs, exp);
            end
        end
    endtask

    task automatic test_last_wins();
        logic [2:0] obs, exp;
        logic [2:0] pre_seq [5];
        logic [2:0] bnd_seq [7];
        pre_seq = '{3'b100, 3'b100, 3'b000, 3'b000, 3'b111};
        bnd_seq = '{3'b100, 3'b000, 3'b111, 3'b100, 3'b000, 3'b000, 3'b110};
        apply_reset();
        enable = 1'b1;
        cyc();
        ndiv = 8'd5; ndiv_load = 1'b1;
        cyc();
        ndiv_load = 1'b0;
        cyc();
        // Two loads inside one ratio-5 period; only the second may take effect.
        for (int j = 0; j < 5; j++) begin
            ndiv_load = (j < 2);
            ndiv      = (j == 0) ? 8'd7 : 8'd3;
            cyc();
            obs = {div_out, div_pulse, ndiv_ack};
            checks++;
            if (obs !== pre_seq[j]) begin
                errors++;
                $display("FAIL last_wins_pre[%0d]: got %b expected %b", j, obs, pre_seq[j]);
            end
        end
        ndiv_load = 1'b0;
        for (int j = 1; j < 6; j++) begin
            cyc();
            obs = {div_out, div_pulse, ndiv_ack};
            exp = {(j % 3) < 2, (j % 3) == 0, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL last_wins_n3[%0d]: got %b expected %b", j, obs, exp);
            end
        end
        ndiv = 8'd4; ndiv_load = 1'b1;
        cyc();
        ndiv_load = 1'b0;
        obs = {div_out, div_pulse, ndiv_ack};
        checks++;
        if (obs !== 3'b110) begin
            errors++;
            $display("FAIL boundary_load_edge: got %b expected 110", obs);
        end
        for (int j = 0; j < 7; j++) begin
            cyc();
            obs = {div_out, div_pulse, ndiv_ack};
            checks++;
            if (obs !== bnd_seq[j]) begin
                errors++;
                $display("FAIL boundary_load[%0d]: got %b expected %b", j, obs, bnd_seq[j]);
            end
        end
    endtask

    task automatic test_enable_hold();
        logic [2:0] obs;
        logic [2:0] run_seq [5];
        run_seq = '{3'b100, 3'b100, 3'b000, 3'b000, 3'b110};
        apply_reset();
        enable = 1'b1;
        cyc();
        ndiv = 8'd5; ndiv_load = 1'b1;
        cyc();
        ndiv_load = 1'b0;
        cyc();
        enable = 1'b0;
        for (int j = 0; j < 4; j++) begin
            cyc();
            obs = {div_out, div_pulse, ndiv_ack};
            checks++;
            if (obs !== 3'b100) begin
                errors++;
                $display("FAIL enable_hold[%0d]: got %b expected 100", j, obs);
            end
        end
        enable = 1'b1;
        for (int j = 0; j < 5; j++) begin
            cyc();
            obs = {div_out, div_pulse, ndiv_ack};
            checks++;
            if (obs !== run_seq[j]) begin
                errors++;
                $display("FAIL enable_resume[%0d]: got %b expected %b", j, obs, run_seq[j]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0] obs, exp;
        apply_reset();
        enable = 1'b1;
        cyc();
        ndiv = 8'd5; ndiv_load = 1'b1;
        cyc();
        ndiv_load = 1'b0;
        cyc();
        cyc();
        ndiv = 8'd7; ndiv_load = 1'b1;
        cyc();
        ndiv_load = 1'b0;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        obs = {div_out, div_pulse, ndiv_ack};
        checks++;
        if (obs !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_clear: got %b expected 000", obs);
        end
        for (int j = 0; j < 6; j++) begin
            cyc();
            obs = {div_out, div_pulse, ndiv_ack};
            exp = {j % 2 == 0, j % 2 == 0, 1'b0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_mid_restart[%0d]: got %b expected %b", j, obs, exp);
            end
        end
    endtask

`ifdef FREQ_DIV_FRAC_EN
    task automatic test_frac();
        int cycles = 0;
        int periods = 0;
        int long_cnt = 0;
        int plen = 0;
        int bad_len = 0;
        apply_reset();
        frac = 4'd4;
        enable = 1'b1;
        cyc();
        ndiv = 8'd4; ndiv_load = 1'b1;
        cyc();
        ndiv_load = 1'b0;
        cyc();
        checks++;
        if (!(div_pulse && ndiv_ack)) begin
            errors++;
            $display("FAIL frac_apply: got pulse=%b ack=%b expected 1 1", div_pulse, ndiv_ack);
        end
        while (periods < 16 && cycles < 200) begin
            cyc();
            cycles++;
            plen++;
            if (div_pulse) begin
                periods++;
                if (plen == 5) long_cnt++;
                else if (plen != 4) bad_len++;
                plen = 0;
            end
        end
        checks++;
        if (cycles != 68) begin
            errors++;
            $display("FAIL frac_total: got %0d cycles expected 68", cycles);
        end
        checks++;
        if (long_cnt != 4 || bad_len != 0) begin
            errors++;
            $display("FAIL frac_mix: got %0d long, %0d bad expected 4 long, 0 bad", long_cnt, bad_len);
        end
        frac = 4'd0;
    endtask
`endif

    initial begin
        reset = 1'b1; enable = 1'b0; ndiv = '0; ndiv_load = 1'b0; frac = '0;
        cyc();
        test_reset();
        test_div2();
        test_load5();
        test_n0_n1_n255();
        test_last_wins();
        test_enable_hold();
        test_reset_mid();
`ifdef FREQ_DIV_FRAC_EN
        test_frac();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
